// File: rtl/m_dm_access_ctrl_pkg.sv
// Shared definitions for the M-stage data-memory access controller.
//   - dp_* width/extension codes carried on req_sel
//   - controller FSM state type
//   - latched request record
//   - default DM geometry
//   - alignment helper used when a request is accepted
package m_dm_access_ctrl_pkg;

  // Width/extension codes. Codes 5..7 are undefined.
  // An undefined code behaves as a full-word access with no alignment rule.
  localparam logic [2:0] DP_W  = 3'd0;
  localparam logic [2:0] DP_H  = 3'd1;
  localparam logic [2:0] DP_B  = 3'd2;
  localparam logic [2:0] DP_HU = 3'd3;
  localparam logic [2:0] DP_BU = 3'd4;

  localparam logic [31:0] DM_BYTES_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] DM_BASE_DEFAULT  = 32'h0000_0000;

  typedef enum logic [1:0] {
    DMC_IDLE = 2'd0,
    DMC_WAIT = 2'd1,
    DMC_DONE = 2'd2
  } dmc_state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dm_req_t;

  // Natural alignment: words on 4-byte, halfwords on 2-byte boundaries.
  function automatic logic is_misaligned(input logic [2:0] sel, input logic [1:0] addr_lo);
    case (sel)
      DP_W:        return addr_lo != 2'b00;
      DP_H, DP_HU: return addr_lo[0];
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/m_dm_access_ctrl_lane_unit.sv
// m_lane_unit: combinational byte-lane mapping for the DM access controller.
// Ports:
//   sel       in  3   width/extension code (dp_*)
//   addr_lo   in  2   byte offset within the word
//   wdata     in  32  right-justified store data
//   rdata     in  32  word returned by the DM
//   be        out 4   byte enables for a store of this width
//   wdata_ln  out 32  store data replicated across all lanes
//   rdata_ext out 32  selected lane of rdata, sign- or zero-extended
module m_lane_unit
  import m_dm_access_ctrl_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_ln,
  output logic [31:0] rdata_ext
);

  logic [15:0] rd_half;
  logic [7:0]  rd_byte;

  // Store side.
  // Unsigned codes pick the same lanes as their signed counterparts.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves a value unassigned and infers a latch.
    be       = 4'b1111;
    wdata_ln = wdata;
    case (sel)
      DP_H, DP_HU: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_ln = {2{wdata[15:0]}};
      end
      DP_B, DP_BU: begin
        be       = 4'b0001 << addr_lo;
        wdata_ln = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // Load side.
  always_comb begin
    rd_half   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    rd_byte   = rdata[8*addr_lo +: 8];
    rdata_ext = rdata;
    case (sel)
      DP_H:    rdata_ext = {{16{rd_half[15]}}, rd_half};
      DP_HU:   rdata_ext = {16'h0000, rd_half};
      DP_B:    rdata_ext = {{24{rd_byte[7]}}, rd_byte};
      DP_BU:   rdata_ext = {24'h000000, rd_byte};
      default: ;
    endcase
  end

endmodule

// File: rtl/m_dm_access_ctrl.sv
// m_dm_access_ctrl: sequences one M-stage load/store at a time against a
// variable-latency DM port (mem_req / mem_ready).
// The pipeline is stalled until the access completes.
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   req_valid/we/sel/addr/wdata
//                           M-stage access, held stable while stall=1
//   stall                   hold F/D/E/M; req_valid & (state != DONE)
//   done                    one-cycle pulse; rd_data/err valid
//   rd_data                 extended load data; 0 for stores and errors
//   err                     misaligned or out-of-range access
//   mem_req/we/addr/be/wdata
//                           DM request, driven only while waiting on the DM
//   mem_ready, mem_rdata    DM completion and read word
// Flow:
//   IDLE -> WAIT -> DONE for a legal access.
//   IDLE -> DONE for a rejected one, which never reaches the DM.
module m_dm_access_ctrl
  import m_dm_access_ctrl_pkg::*;
#(
  parameter logic [31:0] DM_BYTES = DM_BYTES_DEFAULT,
  parameter logic [31:0] DM_BASE  = DM_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_sel,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  dmc_state_e  state, state_nxt;
  dm_req_t     req_q;
  logic        req_err;
  logic [31:0] addr_off;
  logic        accept;
  logic        complete;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  // Error classification of the incoming request.
  // The subtraction wraps, so addresses below DM_BASE also land out of range.
  always_comb begin
    addr_off = req_addr - DM_BASE;
    req_err  = is_misaligned(req_sel, req_addr[1:0]) || (addr_off >= DM_BYTES);
  end

  assign accept   = (state == DMC_IDLE) && req_valid;
  assign complete = (state == DMC_WAIT) && mem_ready;

  // Lane mapping works from the latched request.
  // A protocol violation on req_* mid-access therefore cannot corrupt it.
  m_lane_unit u_lane (
    .sel       (req_q.sel),
    .addr_lo   (req_q.addr[1:0]),
    .wdata     (req_q.wdata),
    .rdata     (mem_rdata),
    .be        (lane_be),
    .wdata_ln  (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state is updated with non-blocking assignments.
    // Every flop then samples pre-edge values, whatever order the blocks run in.
    if (reset) state <= DMC_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  // mem_ready is only looked at in WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      DMC_IDLE: if (req_valid) state_nxt = req_err ? DMC_DONE : DMC_WAIT;
      DMC_WAIT: if (mem_ready) state_nxt = DMC_DONE;
      DMC_DONE: state_nxt = DMC_IDLE;
      default:  state_nxt = DMC_IDLE;
    endcase
  end

  // Outputs decoded from state.
  // The DM bus is zero whenever no request is outstanding.
  always_comb begin
    stall     = req_valid && (state != DMC_DONE);
    done      = (state == DMC_DONE);
    mem_req   = (state == DMC_WAIT);
    mem_we    = mem_req && req_q.we;
    mem_addr  = mem_req ? {req_q.addr[31:2], 2'b00} : 32'h0;
    mem_be    = mem_req ? (req_q.we ? lane_be : 4'b1111) : 4'b0000;
    mem_wdata = (mem_req && req_q.we) ? lane_wdata : 32'h0;
  end

  // Request latch and result registers.
  // rd_data/err change only when entering DONE, then hold until the next access ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q   <= '0;
      rd_data <= 32'h0;
      err     <= 1'b0;
    end else begin
      if (accept) begin
        req_q.we    <= req_we;
        req_q.sel   <= req_sel;
        req_q.addr  <= req_addr;
        req_q.wdata <= req_wdata;
        if (req_err) begin
          rd_data <= 32'h0;
          err     <= 1'b1;
        end
      end
      if (complete) begin
        rd_data <= req_q.we ? 32'h0 : lane_rdata;
        err     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_m_dm_access_ctrl.sv
// Self-checking bench for m_dm_access_ctrl.
// Directed spec scenarios plus randomized accesses.
// Expected values come from an arithmetic reference model.
module tb_m_dm_access_ctrl;
  import m_dm_access_ctrl_pkg::*;

  localparam logic [31:0] BYTES = 32'h0000_3000;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_sel;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done, err;
  logic [31:0] rd_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] last_rd;
  logic        last_err;

  always #5 clk = ~clk;

  m_dm_access_ctrl #(.DM_BYTES(BYTES), .DM_BASE(BASE)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_sel(req_sel),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .rd_data(rd_data), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  // What one access looks like from outside.
  // k counts cycles from the IDLE cycle in which the request is presented (k=1).
  typedef struct {
    int          done_k;
    int          first_req_k;
    int          req_cycles;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rd;
    logic        err;
    logic        stable;
    logic        stall_ok;
    logic        timeout;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic logic m_err(input logic [2:0] sel, input logic [31:0] addr);
    logic mis;
    mis = ((sel == DP_W) && (addr % 4 != 0)) ||
          (((sel == DP_H) || (sel == DP_HU)) && (addr % 2 != 0));
    return mis || ((addr - BASE) >= BYTES);
  endfunction

  function automatic logic [3:0] m_be(input logic we, input logic [2:0] sel, input logic [31:0] addr);
    if (!we) return 4'hF;
    if (sel == DP_H || sel == DP_HU) return ((addr % 4) >= 2) ? 4'hC : 4'h3;
    if (sel == DP_B || sel == DP_BU) return 4'(1 << (addr % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] sel, input logic [31:0] w);
    if (sel == DP_H || sel == DP_HU) return (w & 32'hFFFF) * 32'h0001_0001;
    if (sel == DP_B || sel == DP_BU) return (w & 32'hFF) * 32'h0101_0101;
    return w;
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] sel, input logic [31:0] addr, input logic [31:0] word);
    logic [31:0] v;
    v = word;
    if (sel == DP_H || sel == DP_HU) begin
      v = (word >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
      if (sel == DP_H && v >= 32'h8000) v = v - 32'h1_0000;
    end else if (sel == DP_B || sel == DP_BU) begin
      v = (word >> (8 * (addr % 4))) & 32'hFF;
      if (sel == DP_B && v >= 32'h80) v = v - 32'h100;
    end
    return v;
  endfunction

  function automatic obs_t model(input logic we, input logic [2:0] sel, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
    obs_t e;
    logic bad;
    bad           = m_err(sel, addr);
    e.done_k      = bad ? 2 : 3 + delay;
    e.first_req_k = bad ? 0 : 2;
    e.req_cycles  = bad ? 0 : delay + 1;
    e.addr        = bad ? 32'h0 : addr - (addr % 4);
    e.be          = bad ? 4'h0 : m_be(we, sel, addr);
    e.wdata       = (bad || !we) ? 32'h0 : m_wdata(sel, wdata);
    e.we          = !bad && we;
    e.rd          = (bad || we) ? 32'h0 : m_rd(sel, addr, rdata);
    e.err         = bad;
    e.stable      = 1'b1;
    e.stall_ok    = 1'b1;
    e.timeout     = 1'b0;
    return e;
  endfunction

  function automatic logic [128:0] flat(input obs_t o);
    return {8'(o.done_k), 8'(o.first_req_k), 8'(o.req_cycles), o.addr, o.be, o.wdata,
            o.we, o.rd, o.err, o.stable, o.stall_ok, o.timeout};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("done_k=%0d req_k=%0d req_n=%0d addr=%h be=%b wd=%h we=%b rd=%h err=%b stable=%b stall_ok=%b timeout=%b",
                     o.done_k, o.first_req_k, o.req_cycles, o.addr, o.be, o.wdata, o.we,
                     o.rd, o.err, o.stable, o.stall_ok, o.timeout);
  endfunction

  // ---------------- driver / monitor ----------------
  // Presents one access in the cycle after the next rising edge.
  // Answers it after `delay` wait cycles and records what the DUT did.
  // Returns at the falling edge of the done cycle with req_valid still high.
  task automatic run_access(input logic we, input logic [2:0] sel, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int delay, output obs_t o);
    o.done_k = 0; o.first_req_k = 0; o.req_cycles = 0;
    o.addr = '0; o.be = '0; o.wdata = '0; o.we = 1'b0; o.rd = '0; o.err = 1'b0;
    o.stable = 1'b1; o.stall_ok = 1'b1; o.timeout = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_sel = sel; req_addr = addr; req_wdata = wdata;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        if (k == 2 + delay) begin
          mem_ready = 1'b1;
          mem_rdata = rdata;
        end
      end
      @(negedge clk);
      if (done !== 1'b1 && stall !== 1'b1) o.stall_ok = 1'b0;
      if (done === 1'b1 && stall !== 1'b0) o.stall_ok = 1'b0;
      if (mem_req === 1'b1) begin
        if (o.first_req_k == 0) begin
          o.first_req_k = k;
          o.addr = mem_addr; o.be = mem_be; o.we = mem_we;
          o.wdata = we ? mem_wdata : 32'h0;
        end else if ({mem_addr, mem_be, mem_we} !== {o.addr, o.be, o.we} ||
                     (we && mem_wdata !== o.wdata)) begin
          o.stable = 1'b0;
        end
        o.req_cycles++;
      end
      if (done === 1'b1) begin
        o.done_k = k; o.rd = rd_data; o.err = err;
        break;
      end
    end
    if (o.done_k == 0) o.timeout = 1'b1;
    mem_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_sel = DP_W;
    req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({stall, done, mem_req, mem_we, mem_addr, mem_be, mem_wdata, rd_data, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got stall=%b done=%b req=%b we=%b addr=%h be=%b wd=%h rd=%h err=%b, want all 0",
               stall, done, mem_req, mem_we, mem_addr, mem_be, mem_wdata, rd_data, err);
    end
    @(posedge clk); #1;
    req_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if ({stall, done, mem_req} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_stall_follows_valid: got stall=%b done=%b req=%b, want 1 0 0", stall, done, mem_req);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b0;
    last_rd = 32'h0; last_err = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp_rd;
  } load_vec_t;

  task automatic test_spec_loads();
    load_vec_t tv[5];
    obs_t o, e;
    tv[0] = '{DP_W,  32'h10, 32'hDEADBEEF, 32'hDEADBEEF};
    tv[1] = '{DP_B,  32'h13, 32'h80FF0102, 32'hFFFFFF80};
    tv[2] = '{DP_BU, 32'h13, 32'h80FF0102, 32'h00000080};
    tv[3] = '{DP_H,  32'h12, 32'h80FF0102, 32'hFFFF80FF};
    tv[4] = '{DP_HU, 32'h12, 32'h80FF0102, 32'h000080FF};
    foreach (tv[i]) begin
      run_access(1'b0, tv[i].sel, tv[i].addr, 32'h0, tv[i].rdata, 0, o);
      e = model(1'b0, tv[i].sel, tv[i].addr, 32'h0, tv[i].rdata, 0);
      vectors++;
      if (flat(o) !== flat(e)) begin
        miscompares++;
        $display("FAIL load_%0d: got %s", i, fmt(o));
        $display("     load_%0d: want %s", i, fmt(e));
      end
      vectors++;
      if (o.rd !== tv[i].exp_rd || o.done_k != 3) begin
        miscompares++;
        $display("FAIL load_%0d_literal: got rd=%h done_k=%0d, want rd=%h done_k=3",
                 i, o.rd, o.done_k, tv[i].exp_rd);
      end
      last_rd = e.rd; last_err = e.err;
    end
  endtask

  task automatic test_spec_stores();
    obs_t o;
    run_access(1'b1, DP_H, 32'h06, 32'h1234ABCD, 32'hFFFFFFFF, 0, o);
    vectors++;
    if ({o.we, o.addr, o.be, o.wdata, o.rd, o.err} !== {1'b1, 32'h04, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL store_sh: got %s; want we=1 addr=00000004 be=1100 wd=abcdabcd rd=0 err=0", fmt(o));
    end
    run_access(1'b1, DP_B, 32'h05, 32'h00000077, 32'hFFFFFFFF, 1, o);
    vectors++;
    if ({o.we, o.addr, o.be, o.wdata, o.rd, o.err} !== {1'b1, 32'h04, 4'b0010, 32'h77777777, 32'h0, 1'b0} ||
        o.done_k != 4) begin
      miscompares++;
      $display("FAIL store_sb: got %s; want we=1 addr=00000004 be=0010 wd=77777777 done_k=4", fmt(o));
    end
    last_rd = 32'h0; last_err = 1'b0;
  endtask

  task automatic test_errors();
    obs_t o, e;
    logic [2:0]  sels[4]  = '{DP_W, DP_H, DP_W, DP_B};
    logic [31:0] addrs[4] = '{32'h2, 32'h3001, 32'h3000, 32'h2FFF};
    logic        wes[4]   = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      run_access(wes[i], sels[i], addrs[i], 32'h55AA55AA, 32'hC3C3C3C3, 0, o);
      e = model(wes[i], sels[i], addrs[i], 32'h55AA55AA, 32'hC3C3C3C3, 0);
      vectors++;
      // The first three must be rejected, the last is the highest legal byte.
      if (flat(o) !== flat(e) || o.err !== (i < 3)) begin
        miscompares++;
        $display("FAIL error_case_%0d: got %s; want %s", i, fmt(o), fmt(e));
      end
      last_rd = e.rd; last_err = e.err;
    end
  endtask

  task automatic test_wait_stall();
    obs_t o, e;
    run_access(1'b0, DP_HU, 32'h102, 32'h0, 32'hA5A5_1234, 5, o);
    e = model(1'b0, DP_HU, 32'h102, 32'h0, 32'hA5A5_1234, 5);
    vectors++;
    if (flat(o) !== flat(e) || o.done_k != 8 || o.req_cycles != 6 || o.rd !== 32'h0000A5A5) begin
      miscompares++;
      $display("FAIL long_wait: got %s; want %s", fmt(o), fmt(e));
    end
    last_rd = e.rd; last_err = e.err;
  endtask

  task automatic test_reset_mid_wait();
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_sel = DP_W; req_addr = 32'h20; mem_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    vectors++;
    if ({mem_req, stall, done} !== 3'b110) begin
      miscompares++;
      $display("FAIL mid_wait_before_reset: got req=%b stall=%b done=%b, want 1 1 0", mem_req, stall, done);
    end
    reset = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mem_req, done, stall, rd_data, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_wait: got req=%b done=%b stall=%b rd=%h err=%b, want all 0",
               mem_req, done, stall, rd_data, err);
    end
    reset = 1'b0;
    last_rd = 32'h0; last_err = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      vectors++;
      if ({done, mem_req, stall} !== 3'b000) begin
        miscompares++;
        $display("FAIL post_reset_quiet_%0d: got done=%b req=%b stall=%b, want 0 0 0", c, done, mem_req, stall);
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2, e2;
    run_access(1'b0, DP_W, 32'h40, 32'h0, 32'h1111_2222, 0, o1);
    run_access(1'b0, DP_B, 32'h45, 32'h0, 32'h0000_F000, 1, o2);
    e2 = model(1'b0, DP_B, 32'h45, 32'h0, 32'h0000_F000, 1);
    vectors++;
    if (o1.rd !== 32'h1111_2222 || flat(o2) !== flat(e2) || o2.first_req_k != 2) begin
      miscompares++;
      $display("FAIL back_to_back: first rd=%h want 11112222; second %s; want %s", o1.rd, fmt(o2), fmt(e2));
    end
    last_rd = e2.rd; last_err = e2.err;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      vectors++;
      if ({done, stall, mem_req} !== 3'b000 || rd_data !== last_rd || err !== last_err) begin
        miscompares++;
        $display("FAIL idle_hold_%0d: got done=%b stall=%b req=%b rd=%h err=%b, want 0 0 0 rd=%h err=%b",
                 c, done, stall, mem_req, rd_data, err, last_rd, last_err);
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_random();
    obs_t o, e;
    logic        we;
    logic [2:0]  sel;
    logic [31:0] addr, wdata, rdata;
    int          delay, pick;
    for (int n = 0; n < 200; n++) begin
      we    = 1'($urandom_range(0, 1));
      sel   = 3'($urandom_range(0, 7));
      pick  = $urandom_range(0, 9);
      addr  = (pick < 8) ? 32'($urandom_range(0, 32'h2FFF)) :
              (pick == 8) ? 32'($urandom_range(32'h2FF8, 32'h3007)) : $urandom;
      wdata = $urandom;
      rdata = $urandom;
      delay = $urandom_range(0, 4);
      run_access(we, sel, addr, wdata, rdata, delay, o);
      e = model(we, sel, addr, wdata, rdata, delay);
      vectors++;
      if (flat(o) !== flat(e)) begin
        miscompares++;
        $display("FAIL random_%0d (we=%b sel=%0d addr=%h): got %s", n, we, sel, addr, fmt(o));
        $display("     random_%0d: want %s", n, fmt(e));
      end
      last_rd = e.rd; last_err = e.err;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({done, stall} !== 2'b00 || rd_data !== last_rd || err !== last_err) begin
          miscompares++;
          $display("FAIL random_gap_%0d: got done=%b stall=%b rd=%h err=%b, want 0 0 rd=%h err=%b",
                   n, done, stall, rd_data, err, last_rd, last_err);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_spec_loads();
    test_spec_stores();
    test_errors();
    test_wait_stall();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
